// File: rtl/main_mem_arbiter.sv
// Main-memory port arbiter: round-robin grant of one external memory port
// to NUM_REQ cache miss engines. It issues the winner's command, counts the
// burst beats and gates the beat handshakes back to the granted engine only.
//
// Handshake semantics: a command transfer completes on a cycle where
// mem_cmd_valid_o and mem_cmd_ack_i are both high; command fields are stable
// while valid is high. Data beats are single-cycle strobes (mem_rd_valid_i for
// fills, mem_wr_ack_i for evictions) with no back-pressure from this block.
module main_mem_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 24,
    parameter int BURST_LEN = 512,
    parameter int CNT_W     = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        req_wr_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0]        req_done_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      mem_cmd_valid_o,
    output logic                      mem_cmd_wr_o,
    output logic [ADDR_W-1:0]         mem_cmd_addr_o,
    input  logic                      mem_cmd_ack_i,
    input  logic                      mem_rd_valid_i,
    input  logic                      mem_wr_ack_i,
    output logic [NUM_REQ-1:0]        eng_rd_valid_o,
    output logic [NUM_REQ-1:0]        eng_wr_ack_o,
    output logic                      busy_o,
    output logic [2:0]                state_o,
    output logic [CNT_W-1:0]          beat_cnt_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);

    typedef enum logic [2:0] {
        ARB_IDLE      = 3'd0,
        ARB_CMD       = 3'd1,
        ARB_XFER      = 3'd2,
        ARB_WAIT_DONE = 3'd3,
        ARB_RELEASE   = 3'd4
    } arb_state_e;

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic                cmd_wr_q, cmd_wr_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic [IDX_W-1:0]    win_idx_q, win_idx_d;

    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    int unsigned         cand;
    logic                done_granted;
    logic                beat_in;
    logic [CNT_W-1:0]    beat_cnt_inc;

    // Round-robin search: first requester above last_grant, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(unsigned'(last_grant_q)) + k) % NUM_REQ;
            if (!pick_found && req_i[cand[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign done_granted = |(req_done_i & grant_q);
    assign beat_in      = cmd_wr_q ? mem_wr_ack_i : mem_rd_valid_i;
    assign beat_cnt_inc = beat_cnt_q + CNT_W'(1);

    // Next-state logic; entering ARB_RELEASE drops the grant and clears the
    // counter immediately so the released engine sees no further beats.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_wr_d     = cmd_wr_q;
        cmd_addr_d   = cmd_addr_q;
        beat_cnt_d   = beat_cnt_q;
        last_grant_d = last_grant_q;
        win_idx_d    = win_idx_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_d     = NUM_REQ'(1) << pick_idx;
                    win_idx_d   = pick_idx;
                    cmd_wr_d    = req_wr_i[pick_idx];
                    cmd_addr_d  = req_addr_i[pick_idx*ADDR_W +: ADDR_W];
                    cmd_valid_d = 1'b1;
                    state_d     = ARB_CMD;
                end
            end
            ARB_CMD: begin
                if (done_granted) begin
                    cmd_valid_d = 1'b0;
                    state_d     = ARB_RELEASE;
                end else if (mem_cmd_ack_i) begin
                    cmd_valid_d = 1'b0;
                    state_d     = ARB_XFER;
                end
            end
            ARB_XFER: begin
                if (done_granted) begin
                    state_d = ARB_RELEASE;
                end else if (beat_in) begin
                    beat_cnt_d = beat_cnt_inc;
                    if (beat_cnt_inc == BURST_CNT) begin
                        state_d = ARB_WAIT_DONE;
                    end
                end
            end
            ARB_WAIT_DONE: begin
                if (done_granted) begin
                    state_d = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        if (state_d == ARB_RELEASE && state_q != ARB_RELEASE) begin
            grant_d      = '0;
            beat_cnt_d   = '0;
            last_grant_d = win_idx_q;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_wr_q     <= 1'b0;
            cmd_addr_q   <= '0;
            beat_cnt_q   <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            win_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_wr_q     <= cmd_wr_d;
            cmd_addr_q   <= cmd_addr_d;
            beat_cnt_q   <= beat_cnt_d;
            last_grant_q <= last_grant_d;
            win_idx_q    <= win_idx_d;
        end
    end

    // Zero-latency beat routing, only during the transfer phase.
    always_comb begin
        eng_rd_valid_o = grant_q & {NUM_REQ{mem_rd_valid_i & ~cmd_wr_q & (state_q == ARB_XFER)}};
        eng_wr_ack_o   = grant_q & {NUM_REQ{mem_wr_ack_i & cmd_wr_q & (state_q == ARB_XFER)}};
    end

    assign grant_o         = grant_q;
    assign mem_cmd_valid_o = cmd_valid_q;
    assign mem_cmd_wr_o    = cmd_wr_q;
    assign mem_cmd_addr_o  = cmd_addr_q;
    assign busy_o          = (state_q != ARB_IDLE);
    assign state_o         = state_q;
    assign beat_cnt_o      = beat_cnt_q;

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter: single read, round robin, write burst,
// abort, stray done and reset mid-burst.
module tb_main_mem_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 24;
  localparam int CNT_W   = 10;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_XFER = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_REL  = 3'd4;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_done;
  logic [NUM_REQ-1:0]        grant;
  logic                      cmd_valid;
  logic                      cmd_wr;
  logic [ADDR_W-1:0]         cmd_addr;
  logic                      cmd_ack;
  logic                      rd_valid;
  logic                      wr_ack;
  logic [NUM_REQ-1:0]        eng_rd;
  logic [NUM_REQ-1:0]        eng_wr;
  logic                      busy;
  logic [2:0]                state;
  logic [CNT_W-1:0]          beat_cnt;

  int checks   = 0;
  int failures = 0;

  main_mem_arbiter dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_i           (req),
    .req_wr_i        (req_wr),
    .req_addr_i      (req_addr),
    .req_done_i      (req_done),
    .grant_o         (grant),
    .mem_cmd_valid_o (cmd_valid),
    .mem_cmd_wr_o    (cmd_wr),
    .mem_cmd_addr_o  (cmd_addr),
    .mem_cmd_ack_i   (cmd_ack),
    .mem_rd_valid_i  (rd_valid),
    .mem_wr_ack_i    (wr_ack),
    .eng_rd_valid_o  (eng_rd),
    .eng_wr_ack_o    (eng_wr),
    .busy_o          (busy),
    .state_o         (state),
    .beat_cnt_o      (beat_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Drives n beats; in write mode each beat is followed by gap cycles carrying
  // rd_valid noise. Returns how many cycles each engine-side strobe fired.
  task automatic drive_beats(input int n, input logic wr, input int gap,
                             output int rd_cnt, output int wr_cnt,
                             output logic [NUM_REQ-1:0] rd_mask,
                             output logic [NUM_REQ-1:0] wr_mask);
    rd_cnt = 0; wr_cnt = 0; rd_mask = '0; wr_mask = '0;
    for (int b = 0; b < n; b++) begin
      rd_valid = ~wr;
      wr_ack   = wr;
      #1;
      if (eng_rd != 0) rd_cnt++;
      if (eng_wr != 0) wr_cnt++;
      rd_mask |= eng_rd;
      wr_mask |= eng_wr;
      tick();
      for (int g = 0; g < gap; g++) begin
        rd_valid = 1'b1;
        wr_ack   = 1'b0;
        #1;
        if (eng_rd != 0) rd_cnt++;
        if (eng_wr != 0) wr_cnt++;
        rd_mask |= eng_rd;
        wr_mask |= eng_wr;
        tick();
      end
    end
    rd_valid = 1'b0;
    wr_ack   = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (grant !== 3'b000) begin failures++; $display("FAIL reset_grant got=%b exp=000", grant); end
    checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", cmd_valid); end
    checks++; if (cmd_wr !== 1'b0) begin failures++; $display("FAIL reset_wr got=%b exp=0", cmd_wr); end
    checks++; if (cmd_addr !== 24'h0) begin failures++; $display("FAIL reset_addr got=%h exp=000000", cmd_addr); end
    checks++; if (beat_cnt !== 10'd0) begin failures++; $display("FAIL reset_beat got=%0d exp=0", beat_cnt); end
    checks++; if (state !== S_IDLE || busy !== 1'b0) begin failures++; $display("FAIL reset_state got=%0d/%b exp=0/0", state, busy); end
  endtask

  task automatic test_single_read();
    int rc, wc, rc2, wc2;
    logic [NUM_REQ-1:0] rm, wm, rm2, wm2;
    req_addr = {24'h333333, 24'h222222, 24'h000100};
    req_wr = 3'b000;
    req = 3'b001;
    tick();
    checks++; if (grant !== 3'b001 || cmd_valid !== 1'b1) begin failures++; $display("FAIL rd_grant got=%b/%b exp=001/1", grant, cmd_valid); end
    checks++; if (cmd_addr !== 24'h000100 || cmd_wr !== 1'b0) begin failures++; $display("FAIL rd_cmd got=%h/%b exp=000100/0", cmd_addr, cmd_wr); end
    tick();
    checks++; if (state !== S_CMD || cmd_valid !== 1'b1) begin failures++; $display("FAIL rd_cmd_hold got=%0d/%b exp=1/1", state, cmd_valid); end
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    checks++; if (state !== S_XFER || cmd_valid !== 1'b0) begin failures++; $display("FAIL rd_ack got=%0d/%b exp=2/0", state, cmd_valid); end
    drive_beats(511, 1'b0, 0, rc, wc, rm, wm);
    checks++; if (state !== S_XFER || beat_cnt !== 10'd511) begin failures++; $display("FAIL rd_511 got=%0d/%0d exp=2/511", state, beat_cnt); end
    drive_beats(1, 1'b0, 0, rc2, wc2, rm2, wm2);
    checks++; if (state !== S_WAIT || beat_cnt !== 10'd512) begin failures++; $display("FAIL rd_512 got=%0d/%0d exp=3/512", state, beat_cnt); end
    checks++; if (rc + rc2 != 512 || (rm | rm2) !== 3'b001 || wc + wc2 != 0) begin
      failures++; $display("FAIL rd_route got=%0d/%b/%0d exp=512/001/0", rc + rc2, rm | rm2, wc + wc2);
    end
    rd_valid = 1'b1;
    #1;
    checks++; if (eng_rd !== 3'b000) begin failures++; $display("FAIL rd_wait_gate got=%b exp=000", eng_rd); end
    tick();
    rd_valid = 1'b0;
    checks++; if (beat_cnt !== 10'd512 || state !== S_WAIT) begin failures++; $display("FAIL rd_wait_cnt got=%0d/%0d exp=512/3", beat_cnt, state); end
    req_done = 3'b001;
    req = 3'b000;
    tick();
    req_done = 3'b000;
    checks++; if (state !== S_REL || grant !== 3'b000) begin failures++; $display("FAIL rd_release got=%0d/%b exp=4/000", state, grant); end
    tick();
    checks++; if (state !== S_IDLE || busy !== 1'b0) begin failures++; $display("FAIL rd_idle got=%0d/%b exp=0/0", state, busy); end
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] exp_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [ADDR_W-1:0]  exp_a [4] = '{24'h111111, 24'h222222, 24'h333333, 24'h111111};
    int rc, wc;
    logic [NUM_REQ-1:0] rm, wm;
    apply_reset();
    req_addr = {24'h333333, 24'h222222, 24'h111111};
    req_wr = 3'b000;
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (grant !== exp_g[i] || state !== S_CMD) begin failures++; $display("FAIL rr_grant%0d got=%b/%0d exp=%b/1", i, grant, state, exp_g[i]); end
      checks++; if (cmd_addr !== exp_a[i]) begin failures++; $display("FAIL rr_addr%0d got=%h exp=%h", i, cmd_addr, exp_a[i]); end
      cmd_ack = 1'b1;
      tick();
      cmd_ack = 1'b0;
      drive_beats(512, 1'b0, 0, rc, wc, rm, wm);
      checks++; if (rm !== exp_g[i] || rc != 512) begin failures++; $display("FAIL rr_route%0d got=%b/%0d exp=%b/512", i, rm, rc, exp_g[i]); end
      req_done = exp_g[i];
      if (i == 3) req = 3'b000;
      tick();
      req_done = 3'b000;
      checks++; if (state !== S_REL || grant !== 3'b000) begin failures++; $display("FAIL rr_rel%0d got=%0d/%b exp=4/000", i, state, grant); end
      tick();
      checks++; if (state !== S_IDLE || grant !== 3'b000) begin failures++; $display("FAIL rr_idle%0d got=%0d/%b exp=0/000", i, state, grant); end
    end
  endtask

  task automatic test_write_burst();
    int rc, wc, rc2, wc2;
    logic [NUM_REQ-1:0] rm, wm, rm2, wm2;
    req_wr = 3'b010;
    req = 3'b010;
    tick();
    checks++; if (grant !== 3'b010 || cmd_wr !== 1'b1 || cmd_addr !== 24'h222222) begin
      failures++; $display("FAIL wr_grant got=%b/%b/%h exp=010/1/222222", grant, cmd_wr, cmd_addr);
    end
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    drive_beats(511, 1'b1, 1, rc, wc, rm, wm);
    checks++; if (state !== S_XFER || beat_cnt !== 10'd511) begin failures++; $display("FAIL wr_511 got=%0d/%0d exp=2/511", state, beat_cnt); end
    drive_beats(1, 1'b1, 1, rc2, wc2, rm2, wm2);
    checks++; if (state !== S_WAIT || beat_cnt !== 10'd512) begin failures++; $display("FAIL wr_512 got=%0d/%0d exp=3/512", state, beat_cnt); end
    checks++; if (wc + wc2 != 512 || (wm | wm2) !== 3'b010 || rc + rc2 != 0) begin
      failures++; $display("FAIL wr_route got=%0d/%b/%0d exp=512/010/0", wc + wc2, wm | wm2, rc + rc2);
    end
    req_done = 3'b010;
    req = 3'b000;
    req_wr = 3'b000;
    tick();
    req_done = 3'b000;
    tick();
    checks++; if (state !== S_IDLE) begin failures++; $display("FAIL wr_idle got=%0d exp=0", state); end
  endtask

  task automatic test_abort();
    int rc, wc;
    logic [NUM_REQ-1:0] rm, wm;
    req = 3'b001;
    tick();
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    drive_beats(100, 1'b0, 0, rc, wc, rm, wm);
    checks++; if (state !== S_XFER || beat_cnt !== 10'd100) begin failures++; $display("FAIL ab_100 got=%0d/%0d exp=2/100", state, beat_cnt); end
    req_done = 3'b001;
    req = 3'b000;
    tick();
    req_done = 3'b000;
    checks++; if (state !== S_REL || grant !== 3'b000 || beat_cnt !== 10'd0) begin
      failures++; $display("FAIL ab_xfer got=%0d/%b/%0d exp=4/000/0", state, grant, beat_cnt);
    end
    tick();
    req = 3'b001;
    tick();
    checks++; if (state !== S_CMD || grant !== 3'b001) begin failures++; $display("FAIL ab_regrant got=%0d/%b exp=1/001", state, grant); end
    req_done = 3'b001;
    req = 3'b000;
    tick();
    req_done = 3'b000;
    checks++; if (state !== S_REL || cmd_valid !== 1'b0 || grant !== 3'b000) begin
      failures++; $display("FAIL ab_cmd got=%0d/%b/%b exp=4/0/000", state, cmd_valid, grant);
    end
    tick();
  endtask

  task automatic test_stray_done();
    int rc, wc;
    logic [NUM_REQ-1:0] rm, wm;
    req = 3'b001;
    tick();
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    drive_beats(10, 1'b0, 0, rc, wc, rm, wm);
    req_done = 3'b100;
    tick();
    req_done = 3'b000;
    checks++; if (state !== S_XFER || grant !== 3'b001 || beat_cnt !== 10'd10) begin
      failures++; $display("FAIL stray_done got=%0d/%b/%0d exp=2/001/10", state, grant, beat_cnt);
    end
    req = 3'b000;
    tick();
    checks++; if (state !== S_XFER || grant !== 3'b001) begin failures++; $display("FAIL stray_req_drop got=%0d/%b exp=2/001", state, grant); end
    req_done = 3'b001;
    tick();
    req_done = 3'b000;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    int rc, wc;
    logic [NUM_REQ-1:0] rm, wm;
    req_wr = 3'b001;
    req = 3'b001;
    tick();
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    drive_beats(300, 1'b1, 0, rc, wc, rm, wm);
    checks++; if (beat_cnt !== 10'd300 || cmd_wr !== 1'b1) begin failures++; $display("FAIL rst_pre got=%0d/%b exp=300/1", beat_cnt, cmd_wr); end
    rst_n = 1'b0;
    wr_ack = 1'b1;
    tick();
    checks++; if (grant !== 3'b000 || cmd_valid !== 1'b0 || cmd_wr !== 1'b0 || cmd_addr !== 24'h0) begin
      failures++; $display("FAIL rst_mid_cmd got=%b/%b/%b/%h exp=000/0/0/000000", grant, cmd_valid, cmd_wr, cmd_addr);
    end
    checks++; if (beat_cnt !== 10'd0 || state !== S_IDLE || busy !== 1'b0 || eng_wr !== 3'b000) begin
      failures++; $display("FAIL rst_mid_state got=%0d/%0d/%b/%b exp=0/0/0/000", beat_cnt, state, busy, eng_wr);
    end
    wr_ack = 1'b0;
    rst_n = 1'b1;
    req_wr = 3'b000;
    req_addr = {24'h333333, 24'h222222, 24'hABCDEF};
    req = 3'b101;
    tick();
    checks++; if (grant !== 3'b001 || cmd_addr !== 24'hABCDEF) begin failures++; $display("FAIL rst_regrant got=%b/%h exp=001/abcdef", grant, cmd_addr); end
    req_done = 3'b001;
    req = 3'b000;
    tick();
    req_done = 3'b000;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_done = '0;
    cmd_ack = 1'b0; rd_valid = 1'b0; wr_ack = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_burst();
    test_abort();
    test_stray_done();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
